// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter state encoding, requester IDs and default bus widths.
package cpu_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;
  localparam int unsigned DEFAULT_DATA_W = 32;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE      = 2'd0;
  localparam arb_state_t ISSUE     = 2'd1;
  localparam arb_state_t WAIT_RESP = 2'd2;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module arb_rr2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  assign gnt[REQ_I] = req[REQ_I] & (~req[REQ_D] | (last == REQ_D));
  assign gnt[REQ_D] = req[REQ_D] & (~req[REQ_I] | (last == REQ_I));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store with one transaction
// in flight, round-robin on contention and a bounded wait for the memory response.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 8;

  arb_state_t         state_q, state_nxt;
  logic               last_q, last_nxt;
  logic               owner_q, owner_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [1:0]         pick;

  logic               mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [DATA_W-1:0]  mem_wdata_nxt;
  logic [STRB_W-1:0]  mem_wstrb_nxt;
  logic               i_rvalid_nxt, i_err_nxt, d_rvalid_nxt, d_err_nxt;
  logic [DATA_W-1:0]  i_rdata_nxt, d_rdata_nxt;
  logic               resp_fire, resp_err;
  logic [DATA_W-1:0]  resp_data;

  arb_rr2 u_rr (
    .req  ({d_req, i_req}),
    .last (last_q),
    .gnt  (pick)
  );

  // Grants are combinational and suppressed while reset is asserted.
  assign i_gnt = reset_n & (state_q == IDLE) & pick[REQ_I];
  assign d_gnt = reset_n & (state_q == IDLE) & pick[REQ_D];

  // Next-state, command latch, timeout and response routing.
  always_comb begin
    state_nxt     = state_q;
    last_nxt      = last_q;
    owner_nxt     = owner_q;
    cnt_nxt       = cnt_q;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_wstrb_nxt = mem_wstrb;
    i_rvalid_nxt  = 1'b0;
    i_err_nxt     = 1'b0;
    i_rdata_nxt   = i_rdata;
    d_rvalid_nxt  = 1'b0;
    d_err_nxt     = 1'b0;
    d_rdata_nxt   = d_rdata;
    resp_fire     = 1'b0;
    resp_err      = 1'b0;
    resp_data     = '0;

    case (state_q)
      IDLE: begin
        if (|pick) begin
          owner_nxt   = pick[REQ_D] ? REQ_D : REQ_I;
          last_nxt    = owner_nxt;
          state_nxt   = ISSUE;
          mem_req_nxt = 1'b1;
          if (pick[REQ_D]) begin
            mem_we_nxt    = d_we;
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
            mem_wstrb_nxt = d_wstrb;
          end else begin
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = i_addr;
            mem_wdata_nxt = '0;
            mem_wstrb_nxt = '0;
          end
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_nxt   = WAIT_RESP;
          mem_req_nxt = 1'b0;
          cnt_nxt     = '0;
        end
      end
      WAIT_RESP: begin
        cnt_nxt = cnt_q + CNT_W'(1);
        // A response landing on the timeout cycle wins over the error.
        if (mem_rvalid || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          resp_fire = 1'b1;
          resp_err  = ~mem_rvalid;
          resp_data = (mem_rvalid && !mem_we) ? mem_rdata : '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (resp_fire) begin
      if (owner_q == REQ_D) begin
        d_rvalid_nxt = 1'b1;
        d_err_nxt    = resp_err;
        d_rdata_nxt  = resp_data;
      end else begin
        i_rvalid_nxt = 1'b1;
        i_err_nxt    = resp_err;
        i_rdata_nxt  = resp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_q    <= REQ_I;
      owner_q   <= REQ_I;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      i_rvalid  <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= '0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      state_q   <= state_nxt;
      last_q    <= last_nxt;
      owner_q   <= owner_nxt;
      cnt_q     <= cnt_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_wstrb <= mem_wstrb_nxt;
      i_rvalid  <= i_rvalid_nxt;
      i_err     <= i_err_nxt;
      i_rdata   <= i_rdata_nxt;
      d_rvalid  <= d_rvalid_nxt;
      d_err     <= d_err_nxt;
      d_rdata   <= d_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned T  = 4;
  localparam int          NCYC = 2000;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            i_req, i_gnt, i_rvalid, i_err;
  logic [AW-1:0]   i_addr;
  logic [DW-1:0]   i_rdata;
  logic            d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata, d_rdata;
  logic [DW/8-1:0] d_wstrb;
  logic            mem_req, mem_we, mem_ready, mem_rvalid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [DW/8-1:0] mem_wstrb;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .i_err      (i_err),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wstrb    (d_wstrb),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
              mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb}, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model state for the randomized run
  bit            free, issuing, last_d, ip, dp, due, win_i, win_d, cmd_d, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, rv_data, resp_data;
  logic [3:0]    cmd_wstrb;
  int            resp_cyc, rv_cyc, dly;
  bit            resp_d, resp_err;

  initial begin
    reset_n = 1'b1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;

    // Reset: everything low even with both requesters active
    #3 reset_n = 1'b0;
    i_req = 1; d_req = 1;
    #1 chk_all_zero("reset_outputs");
    next_cycle();
    next_cycle();
    chk_all_zero("reset_held");

    // Contention from reset: D, I, D, I
    reset_n = 1'b1;
    i_addr = 32'h40; d_addr = 32'h80; d_we = 0; mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cont%0d_d_gnt", k), d_gnt, (k % 2) == 0);
      chk($sformatf("cont%0d_i_gnt", k), i_gnt, (k % 2) == 1);
      next_cycle();
      #1;
      chk($sformatf("cont%0d_busy_gnt", k), {i_gnt, d_gnt}, 2'b00);
      chk($sformatf("cont%0d_mem_req", k), mem_req, 1'b1);
      chk($sformatf("cont%0d_mem_addr", k), mem_addr, ((k % 2) == 0) ? 32'h80 : 32'h40);
      next_cycle();
      mem_rvalid = 1; mem_rdata = 32'h1000 + 32'(k);
      #1 chk($sformatf("cont%0d_req_low", k), mem_req, 1'b0);
      next_cycle();
      mem_rvalid = 0;
      #1;
      chk($sformatf("cont%0d_d_rvalid", k), d_rvalid, (k % 2) == 0);
      chk($sformatf("cont%0d_i_rvalid", k), i_rvalid, (k % 2) == 1);
      chk($sformatf("cont%0d_rdata", k), ((k % 2) == 0) ? d_rdata : i_rdata, 32'h1000 + 32'(k));
    end
    i_req = 0; d_req = 0;

    // Lone fetch, best-case latency
    next_cycle();
    i_req = 1; i_addr = 32'h10; mem_ready = 1;
    #1;
    chk("fetch_i_gnt", i_gnt, 1'b1);
    chk("fetch_d_gnt", d_gnt, 1'b0);
    next_cycle();
    i_req = 0;
    #1;
    chk("fetch_mem_req", mem_req, 1'b1);
    chk("fetch_mem_addr", mem_addr, 32'h10);
    chk("fetch_we_strb", {mem_we, mem_wstrb}, 5'b0);
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'h13;
    #1 chk("fetch_early_rvalid", {i_rvalid, d_rvalid}, 2'b00);
    next_cycle();
    mem_rvalid = 0;
    #1;
    chk("fetch_i_rvalid", i_rvalid, 1'b1);
    chk("fetch_i_rdata", i_rdata, 32'h13);
    chk("fetch_i_err", i_err, 1'b0);
    chk("fetch_d_rvalid", d_rvalid, 1'b0);
    next_cycle();
    #1 chk("fetch_pulse", i_rvalid, 1'b0);

    // Store with three stall cycles
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF; mem_ready = 0;
    #1 chk("store_d_gnt", d_gnt, 1'b1);
    for (int s = 0; s < 4; s++) begin
      next_cycle();
      if (s == 0) d_req = 0;
      mem_ready = (s == 3);
      #1;
      chk($sformatf("store%0d_cmd", s), {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb},
          {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
    end
    next_cycle();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
    #1 chk("store_req_low", mem_req, 1'b0);
    next_cycle();
    mem_rvalid = 0;
    #1 chk("store_resp", {d_rvalid, d_err, d_rdata, i_rvalid}, {1'b1, 1'b0, 32'h0, 1'b0});

    // Timeout with a late response afterwards
    next_cycle();
    d_req = 1; d_we = 0; d_addr = 32'h200; mem_ready = 1;
    #1 chk("tmo_d_gnt", d_gnt, 1'b1);
    next_cycle();
    d_req = 0;
    #1 chk("tmo_handshake", mem_req, 1'b1);
    for (int w = 1; w <= 4; w++) begin
      next_cycle();
      #1 chk($sformatf("tmo_wait%0d", w), {d_rvalid, i_rvalid}, 2'b00);
    end
    next_cycle();
    #1 chk("tmo_resp", {d_rvalid, d_err, d_rdata, i_rvalid}, {1'b1, 1'b1, 32'h0, 1'b0});
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    #1 chk("tmo_pulse", d_rvalid, 1'b0);
    next_cycle();
    mem_rvalid = 0;
    #1 chk("tmo_late_dropped", {d_rvalid, i_rvalid, d_err, i_err}, 4'b0);

    // Response arriving on the timeout cycle
    next_cycle();
    d_req = 1; d_addr = 32'h300;
    #1 chk("tie_d_gnt", d_gnt, 1'b1);
    next_cycle();
    d_req = 0;
    #1 chk("tie_handshake", mem_req, 1'b1);
    repeat (3) next_cycle();
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
    #1 chk("tie_early", d_rvalid, 1'b0);
    next_cycle();
    mem_rvalid = 0;
    #1 chk("tie_resp", {d_rvalid, d_err, d_rdata}, {1'b1, 1'b0, 32'hCAFE0001});

    // Asynchronous reset during WAIT_RESP, D owned the last grant
    next_cycle();
    d_req = 1; d_addr = 32'h400;
    #1 chk("rst_d_gnt", d_gnt, 1'b1);
    next_cycle();
    d_req = 0;
    next_cycle();
    i_req = 1; d_req = 1;
    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset_mid");
    mem_rvalid = 1; mem_rdata = 32'h5151;
    next_cycle();
    chk_all_zero("reset_mid_held");
    reset_n = 1'b1;
    #1;
    chk("post_rst_d_gnt", d_gnt, 1'b1);
    chk("post_rst_i_gnt", i_gnt, 1'b0);
    next_cycle();
    mem_rvalid = 0; d_req = 0; mem_ready = 0;
    #1;
    chk("post_rst_cmd", {mem_req, mem_addr}, {1'b1, 32'h400});
    chk("post_rst_no_stale", {i_rvalid, d_rvalid}, 2'b00);
    next_cycle();
    #1 chk("post_rst_no_stale2", {i_rvalid, d_rvalid}, 2'b00);

    // Randomized run from a fresh reset
    i_req = 0; d_req = 0; mem_ready = 0; mem_rvalid = 0;
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    free = 1; issuing = 0; last_d = 0; ip = 0; dp = 0;
    resp_cyc = -1; rv_cyc = -1;
    for (int c = 0; c < NCYC; c++) begin
      next_cycle();
      due = (c == resp_cyc);
      if (due) free = 1;

      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; i_addr = $urandom;
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
      end
      i_req = ip; d_req = dp;
      mem_ready = issuing ? ($urandom_range(0, 2) != 0) : 1'($urandom);
      mem_rdata = $urandom;
      if (c == rv_cyc) begin
        mem_rvalid = 1; mem_rdata = rv_data;
      end else if ((free || issuing) && $urandom_range(0, 5) == 0) begin
        mem_rvalid = 1;
      end else begin
        mem_rvalid = 0;
      end
      #1;

      chk($sformatf("rnd%0d_mem_req", c), mem_req, issuing);
      if (issuing) begin
        chk($sformatf("rnd%0d_cmd", c), {mem_we, mem_addr, mem_wstrb}, {cmd_we, cmd_addr, cmd_wstrb});
        if (cmd_d) chk($sformatf("rnd%0d_wdata", c), mem_wdata, cmd_wdata);
      end
      chk($sformatf("rnd%0d_i_rvalid", c), i_rvalid, due && !resp_d);
      chk($sformatf("rnd%0d_d_rvalid", c), d_rvalid, due && resp_d);
      if (due) begin
        chk($sformatf("rnd%0d_resp", c), resp_d ? {d_err, d_rdata} : {i_err, i_rdata},
            {resp_err, resp_data});
      end

      win_d = free && dp && (!ip || !last_d);
      win_i = free && ip && (!dp || last_d);
      chk($sformatf("rnd%0d_gnt", c), {i_gnt, d_gnt}, {win_i, win_d});

      if (issuing && mem_ready) begin
        issuing = 0;
        dly = $urandom_range(1, T + 2);
        rv_cyc = c + dly;
        rv_data = $urandom;
        resp_d = cmd_d;
        if (dly <= T) begin
          resp_cyc = c + dly + 1; resp_err = 0;
          resp_data = cmd_we ? 32'h0 : rv_data;
        end else begin
          resp_cyc = c + T + 1; resp_err = 1; resp_data = 32'h0;
        end
      end

      if (win_i || win_d) begin
        free = 0; issuing = 1; last_d = win_d; cmd_d = win_d;
        if (win_d) begin
          cmd_we = d_we; cmd_addr = d_addr; cmd_wdata = d_wdata; cmd_wstrb = d_wstrb; dp = 0;
        end else begin
          cmd_we = 0; cmd_addr = i_addr; cmd_wdata = '0; cmd_wstrb = '0; ip = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
